button_click_classifier: RTL
============================

# button_click_classifier

Downstream stage of the push-button debouncer. Consumes the debounced one-cycle press/release edge pulses and classifies each gesture as single click, double click or long press, with optional auto-repeat while a long press is held. Sits between the debouncer and the user-interface control logic (menu/counter FSMs), which need one-cycle event pulses and no raw levels.

## Interface
- `LONG_CYCLES`, default 25_000_000: press duration, in cycles, that qualifies as a long press; must be ≥ 2.
- `DCLICK_CYCLES`, default 10_000_000: window after the first release in which a second press makes a double click; must be ≥ 2.
- `REPEAT_CYCLES`, default 5_000_000: auto-repeat period while long-held; 0 disables repeat.
- `CNT_W`, default 25: width of internal counters; must hold max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pb_posedge` in 1: one-cycle press pulse from the debouncer.
- `pb_negedge` in 1: one-cycle release pulse from the debouncer.
- `single_click` out 1: one-cycle pulse, registered.
- `double_click` out 1: one-cycle pulse, registered.
- `long_press` out 1: one-cycle pulse at the long-press threshold, registered.
- `repeat_tick` out 1: one-cycle pulse every REPEAT_CYCLES while long-held, registered.
- `busy` out 1: high whenever state ≠ IDLE, registered.

## Operation
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, HELD. Main counter `cnt` clears on every state change and increments otherwise.
- IDLE: on `pb_posedge`, go to PRESS1. Ignore `pb_negedge`.
- PRESS1: on `pb_negedge`, go to WAIT2. Otherwise, when `cnt == LONG_CYCLES-1`, pulse `long_press` and go to HELD.
- WAIT2: on `pb_posedge`, go to PRESS2. Otherwise, when `cnt == DCLICK_CYCLES-1`, pulse `single_click` and go to IDLE.
- PRESS2: on `pb_negedge`, pulse `double_click` and go to IDLE. There is no long-press detection in PRESS2 and the counter is frozen.
- HELD: on `pb_negedge`, go to IDLE with no event. A repeat counter clears on entry. When it reaches REPEAT_CYCLES-1, pulse `repeat_tick` and wrap to 0. The repeat logic is inactive when REPEAT_CYCLES = 0.
- Simultaneous `pb_posedge` and `pb_negedge` is a protocol violation. `pb_negedge` has priority in every state.
- Edge priority over timeout in the same cycle: in PRESS1, release wins over long press; in WAIT2, the second press wins over single click.
- At most one of the four event outputs is high in any cycle.
- Counters saturate at their compare value and never wrap except the repeat counter.

## Timing
- Reset: state IDLE, all counters 0, all outputs 0. Reset mid-gesture drops the gesture silently; no event pulse follows reset.
- Latency: an event output is high for exactly the one cycle after the clock edge that samples the triggering condition.
- Edge numbering: let the press pulse be sampled at edge k, which enters PRESS1.
  - `long_press` is high in the cycle after edge k+LONG_CYCLES, if no release was sampled at edges k+1…k+LONG_CYCLES.
  - `single_click` is high DCLICK_CYCLES edges after the release that entered WAIT2.
  - `double_click` is high in the cycle after the edge sampling the second release.
  - The first `repeat_tick` is REPEAT_CYCLES edges after entry into HELD; subsequent ticks follow every REPEAT_CYCLES edges.
- `busy` rises with the PRESS1 entry edge and falls with the IDLE entry edge.
- No input handshake: edge pulses arriving while their state ignores them are dropped.

## Structure
- Shared package `button_pkg`:
  - state enum `click_state_t`;
  - event code constants EV_NONE=0, EV_SINGLE=1, EV_DOUBLE=2, EV_LONG=3, for consumers that encode events.
- One natural sub-module, `press_timer`: a CNT_W-bit up-counter with synchronous clear, enable and terminal-count compare flag. It is instantiated twice, once for the main counter and once for the repeat counter.

## Test plan
Use LONG_CYCLES=8, DCLICK_CYCLES=5, REPEAT_CYCLES=4.
- Single click: press at edge 10, release at edge 13 → `single_click`=1 only in the cycle after edge 18; `busy` is high from edge 10 to edge 18.
- Double click: press at 10, release at 12, press at 14, release at 20 → `double_click` pulse after edge 20; no `single_click`.
- Long press with repeat: press at 10, release at 40 → `long_press` after edge 18; `repeat_tick` after edges 22, 26, 30, 34, 38; no other event.
- Boundary cases:
  - Release sampled exactly at edge 18 (press at 10) → WAIT2; no `long_press`.
  - Second press at exactly edge 17 (release at 12) → PRESS2; no `single_click`.
- Reset in WAIT2 (press 10, release 12, `rst` asserted at 14) → all outputs 0, IDLE; no `single_click` ever follows.
- Stray and simultaneous pulses:
  - Lone `pb_negedge` in IDLE → nothing.
  - `pb_posedge` and `pb_negedge` together in PRESS1 → WAIT2 (negedge priority).

Source files
------------

// File: rtl/button_pkg.sv
// Shared types for the push-button gesture classifier.
// Event codes are for consumers that encode the pulse outputs.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } click_state_t;

  typedef logic [1:0] ev_code_t;

  localparam ev_code_t EV_NONE   = 2'd0;
  localparam ev_code_t EV_SINGLE = 2'd1;
  localparam ev_code_t EV_DOUBLE = 2'd2;
  localparam ev_code_t EV_LONG   = 2'd3;

endpackage

// File: rtl/press_timer.sv
// Saturating up-counter with sync clear, enable and a
// terminal-count flag against a runtime limit.
module press_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             at_term
);

  logic [CNT_W-1:0] count;

  assign at_term = (count == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_term) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/button_click_classifier.sv
// Classifies debounced press/release pulses into single click,
// double click, long press and auto-repeat event pulses.
module button_click_classifier
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int DCLICK_CYCLES = 10_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_posedge,
  input  logic pb_negedge,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam bit REP_ON = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLK_T = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T =
    REP_ON ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  click_state_t     state;
  click_state_t     nxt;
  ev_code_t         ev;
  logic             rep;
  logic             m_term;
  logic             r_term;
  logic [CNT_W-1:0] m_limit;

  assign m_limit = (state == PRESS1) ? LONG_T : DCLK_T;

  press_timer #(.CNT_W(CNT_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear   (nxt != state),
    .enable  ((state == PRESS1) || (state == WAIT2)),
    .limit   (m_limit),
    .at_term (m_term)
  );

  // Wrap is a clear on terminal count; leaving HELD also clears.
  press_timer #(.CNT_W(CNT_W)) u_rep (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state != HELD) || r_term),
    .enable  ((state == HELD) && REP_ON),
    .limit   (REP_T),
    .at_term (r_term)
  );

  always_comb begin
    nxt = state;
    ev  = EV_NONE;
    rep = 1'b0;
    unique case (state)
      IDLE: begin
        if (pb_posedge && !pb_negedge) nxt = PRESS1;
      end
      PRESS1: begin
        if (pb_negedge) begin
          nxt = WAIT2;
        end else if (m_term) begin
          nxt = HELD;
          ev  = EV_LONG;
        end
      end
      WAIT2: begin
        if (pb_posedge && !pb_negedge) begin
          nxt = PRESS2;
        end else if (m_term) begin
          nxt = IDLE;
          ev  = EV_SINGLE;
        end
      end
      PRESS2: begin
        if (pb_negedge) begin
          nxt = IDLE;
          ev  = EV_DOUBLE;
        end
      end
      HELD: begin
        if (pb_negedge) begin
          nxt = IDLE;
        end else if (REP_ON && r_term) begin
          rep = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt;
      single_click <= (ev == EV_SINGLE);
      double_click <= (ev == EV_DOUBLE);
      long_press   <= (ev == EV_LONG);
      repeat_tick  <= rep;
      busy         <= (nxt != IDLE);
    end
  end

endmodule
